// File: rtl/frog_collision_ctrl.sv
// Player-state and collision controller for the lane-scrolling road game.
// Tracks the player's grid position from move pulses, detects car hits against
// the lane occupancy words and goal crossings, and keeps lives and score.
module frog_collision_ctrl #(
    parameter int unsigned COLS        = 16,
    parameter int unsigned ROWS        = 8,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned START_LIVES = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     up,
    input  logic                     down,
    input  logic                     left,
    input  logic                     right,
    input  logic [ROWS*COLS-1:0]     laneCars,
    output logic [$clog2(ROWS)-1:0]  playerRow,
    output logic [$clog2(COLS)-1:0]  playerCol,
    output logic                     hit,
    output logic                     win,
    output logic                     gameOver,
    output logic [2:0]               lives,
    output logic [7:0]               score
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
    localparam logic [RW-1:0] LANE_TOP  = RW'(ROWS - 2);
    localparam logic [CW-1:0] START_COL = CW'(COLS / 2);
    localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    LIVES_RST = 3'(START_LIVES);

    typedef enum logic [1:0] {StPlay, StHit, StWin, StOver} state_e;

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [2:0]      lives_q, lives_d;
    logic [7:0]      score_q, score_d;
    logic [HW-1:0]   hold_q, hold_d;

    logic [COLS-1:0] lane [ROWS];
    logic            collide;

    // Split the flat occupancy bus into per-row words and test the player cell.
    always_comb begin
        for (int r = 0; r < int'(ROWS); r++) begin
            lane[r] = laneCars[r*COLS +: COLS];
        end
        collide = lane[row_q][col_q] && (row_q != '0) && (row_q != LAST_ROW);
    end

    // Next-state logic: collision beats movement; one move per cycle.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        lives_d = lives_q;
        score_d = score_q;
        hold_d  = hold_q;
        unique case (state_q)
            StPlay: begin
                if (collide) begin
                    state_d = StHit;
                    hold_d  = '0;
                    if (lives_q != '0) lives_d = lives_q - 3'd1;
                end else if (up) begin
                    row_d = row_q + RW'(1);
                    if (row_q == LANE_TOP) begin
                        state_d = StWin;
                        hold_d  = '0;
                        if (score_q != 8'hff) score_d = score_q + 8'd1;
                    end
                end else if (down) begin
                    if (row_q != '0) row_d = row_q - RW'(1);
                end else if (left) begin
                    if (col_q != '0) col_d = col_q - CW'(1);
                end else if (right) begin
                    if (col_q != LAST_COL) col_d = col_q + CW'(1);
                end
            end
            StHit, StWin: begin
                if (hold_q == HOLD_LAST) begin
                    hold_d = '0;
                    if (state_q == StHit && lives_q == '0) begin
                        state_d = StOver;
                    end else begin
                        state_d = StPlay;
                        row_d   = '0;
                        col_d   = START_COL;
                    end
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            StOver: begin
                // Frozen until reset.
            end
            default: state_d = StPlay;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StPlay;
            row_q   <= '0;
            col_q   <= START_COL;
            lives_q <= LIVES_RST;
            score_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            lives_q <= lives_d;
            score_q <= score_d;
            hold_q  <= hold_d;
        end
    end

    assign playerRow = row_q;
    assign playerCol = col_q;
    assign hit       = (state_q == StHit);
    assign win       = (state_q == StWin);
    assign gameOver  = (state_q == StOver);
    assign lives     = lives_q;
    assign score     = score_q;

endmodule

// File: tb/tb_frog_collision_ctrl.sv
// Directed bench for frog_collision_ctrl: a vector table for the basic moves and
// a hit, plus hand-written sequences for clamping, score saturation, game over
// and reset during a hold.
module tb_frog_collision_ctrl;

    localparam int unsigned COLS = 16;
    localparam int unsigned ROWS = 8;
    localparam int unsigned HOLD = 4;

    logic           clk = 1'b0;
    logic           reset;
    logic           up, down, left, right;
    logic [127:0]   laneCars;
    logic [2:0]     playerRow;
    logic [3:0]     playerCol;
    logic           hit, win, gameOver;
    logic [2:0]     lives;
    logic [7:0]     score;

    int total = 0;
    int bad   = 0;

    frog_collision_ctrl #(
        .COLS        (COLS),
        .ROWS        (ROWS),
        .HOLD_CYCLES (HOLD),
        .START_LIVES (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .laneCars  (laneCars),
        .playerRow (playerRow),
        .playerCol (playerCol),
        .hit       (hit),
        .win       (win),
        .gameOver  (gameOver),
        .lives     (lives),
        .score     (score)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic         u, d, l, r;
        logic [127:0] cars;
        logic [2:0]   row;
        logic [3:0]   col;
        logic         h, w, o;
        logic [2:0]   lv;
        logic [7:0]   sc;
    } vec_t;

    vec_t vecs[14];

    // One clock: drive after the falling edge, sample 1 time unit after the rising edge.
    task automatic step(input logic u, input logic d, input logic l, input logic r,
                        input logic [127:0] c);
        @(negedge clk);
        up = u; down = d; left = l; right = r; laneCars = c;
        @(posedge clk);
        #1;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic idle(input logic [127:0] c);
        step(1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; laneCars = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check(input string nm, input logic [2:0] row, input logic [3:0] col,
                         input logic h, input logic w, input logic o,
                         input logic [2:0] lv, input logic [7:0] sc);
        total++;
        if ({playerRow, playerCol, hit, win, gameOver, lives, score} !==
            {row, col, h, w, o, lv, sc}) begin
            bad++;
            $display("FAIL %s: got row=%0d col=%0d hit=%0b win=%0b over=%0b lives=%0d score=%0d, want row=%0d col=%0d hit=%0b win=%0b over=%0b lives=%0d score=%0d",
                     nm, playerRow, playerCol, hit, win, gameOver, lives, score,
                     row, col, h, w, o, lv, sc);
        end
    endtask

    // Walk from row 0 to the goal and through the win hold.
    task automatic do_win(input logic [7:0] exp_sc, input logic [2:0] lv, input bit full);
        for (int i = 1; i <= 6; i++) step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        check("win_entry", 3'd7, 4'd8, 1'b0, 1'b1, 1'b0, lv, exp_sc);
        for (int i = 0; i < 3; i++) idle('0);
        if (full) check("win_hold", 3'd7, 4'd8, 1'b0, 1'b1, 1'b0, lv, exp_sc);
        idle('0);
        check("win_return", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, lv, exp_sc);
    endtask

    logic [127:0] c1;
    logic [127:0] c40;

    initial begin
        c1  = 128'd1 << 24;   // row 1, col 8
        c40 = 128'd1 << 40;   // row 2, col 8

        //         name         u     d     l     r     cars  row   col   h     w     o     lv    sc
        vecs[0]  = '{"up1",       1'b1, 1'b0, 1'b0, 1'b0, '0,  3'd1, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0};
        vecs[1]  = '{"up2",       1'b1, 1'b0, 1'b0, 1'b0, '0,  3'd2, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0};
        vecs[2]  = '{"up3",       1'b1, 1'b0, 1'b0, 1'b0, '0,  3'd3, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0};
        vecs[3]  = '{"down",      1'b0, 1'b1, 1'b0, 1'b0, '0,  3'd2, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0};
        vecs[4]  = '{"hit_entry", 1'b0, 1'b0, 1'b0, 1'b0, c40, 3'd2, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[5]  = '{"hit_frozen",1'b1, 1'b0, 1'b0, 1'b0, '0,  3'd2, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[6]  = '{"hit_hold3", 1'b0, 1'b0, 1'b0, 1'b0, '0,  3'd2, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[7]  = '{"hit_hold4", 1'b0, 1'b0, 1'b1, 1'b0, '0,  3'd2, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[8]  = '{"hit_return",1'b0, 1'b0, 1'b0, 1'b0, '0,  3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[9]  = '{"up_prio",   1'b1, 1'b0, 1'b1, 1'b1, '0,  3'd1, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[10] = '{"down_back", 1'b0, 1'b1, 1'b0, 1'b0, '0,  3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[11] = '{"down_clamp",1'b0, 1'b1, 1'b0, 1'b0, '0,  3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[12] = '{"left",      1'b0, 1'b0, 1'b1, 1'b0, '0,  3'd0, 4'd7, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};
        vecs[13] = '{"right",     1'b0, 1'b0, 1'b0, 1'b1, '0,  3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0};

        reset = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0; laneCars = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].u, vecs[i].d, vecs[i].l, vecs[i].r, vecs[i].cars);
            check(vecs[i].name, vecs[i].row, vecs[i].col, vecs[i].h, vecs[i].w, vecs[i].o,
                  vecs[i].lv, vecs[i].sc);
        end

        // Column clamping at both edges.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("left_clamp", 3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b0, 1'b1, '0);
        check("right_clamp", 3'd0, 4'd15, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
        check("recenter", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0);

        // 256 goal crossings: score saturates at 255, lives untouched.
        for (int n = 1; n <= 256; n++) begin
            do_win((n > 255) ? 8'd255 : 8'(n), 3'd2, n == 1);
        end

        // Fresh game: three hits of different flavours lead to game over.
        do_reset();
        check("reset2", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);

        // Entering an occupied lane: hit one cycle after arrival.
        step(1'b1, 1'b0, 1'b0, 1'b0, c1);
        check("enter_lane", 3'd1, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);
        idle(c1);
        check("enter_hit", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
        for (int i = 0; i < 3; i++) idle('0);
        check("enter_hold", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd0);
        idle('0);
        check("enter_return", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd2, 8'd0);

        // Car arrives while the player moves away: pre-move position counts.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, 1'b0, c1);
        check("move_away_hit", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd1, 8'd0);
        for (int i = 0; i < 4; i++) idle('0);
        check("move_away_return", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd1, 8'd0);

        // Last life.
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(c1);
        check("last_hit", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 3; i++) idle('0);
        check("last_hold", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd0, 8'd0);
        idle('0);
        check("game_over", 3'd1, 4'd8, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, 1'b1, '1);
        check("over_frozen", 3'd1, 4'd8, 1'b0, 1'b0, 1'b1, 3'd0, 8'd0);
        do_reset();
        check("over_reset", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);

        // Reset during a hit hold.
        do_win(8'd1, 3'd3, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0);
        idle(c1);
        check("mid_hold_hit", 3'd1, 4'd8, 1'b1, 1'b0, 1'b0, 3'd2, 8'd1);
        idle('0);
        do_reset();
        check("mid_hold_reset", 3'd0, 4'd8, 1'b0, 1'b0, 1'b0, 3'd3, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
